// File: rtl/bsg_level_shift_pkg.sv
// ----------------------------------------------------------------------------
// bsg_level_shift_pkg
//
// Shared definitions for the sink (receive-domain) side of a gated
// level-shift crossing.
//
// Contents:
//   bsg_level_shift_width_gp      default data width crossing the shifter
//   bsg_level_shift_sink_state_e  sequencer states, in fixed order
//                                 OFF, SETTLE, ON, DRAIN
// ----------------------------------------------------------------------------
package bsg_level_shift_pkg;

    localparam int bsg_level_shift_width_gp = 16;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        ON     = 2'd2,
        DRAIN  = 2'd3
    } bsg_level_shift_sink_state_e;

endpackage

// File: rtl/bsg_level_shift_settle_counter.sv
// ----------------------------------------------------------------------------
// bsg_level_shift_settle_counter
//
// Counts the cycles the source-side clamp has been released so the sequencer
// knows when the shifted data can be trusted.
//
// Parameters:
//   settle_cycles_p  number of enabled cycles before data is trusted (>=1)
//
// Ports:
//   clk_i    in   sink-domain clock
//   reset_i  in   asynchronous, active-high reset
//   clear_i  in   return the count to zero
//   up_i     in   advance the count by one
//   done_o   out  count has reached settle_cycles_p-1
// ----------------------------------------------------------------------------
module bsg_level_shift_settle_counter
    import bsg_level_shift_pkg::*;
#(
    parameter int settle_cycles_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic up_i,
    output logic done_o
);

    localparam int count_width_lp = $clog2(settle_cycles_p + 1);
    localparam logic [count_width_lp-1:0] terminal_lp = count_width_lp'(settle_cycles_p - 1);
    localparam logic [count_width_lp-1:0] one_lp      = count_width_lp'(1);

    logic [count_width_lp-1:0] count_r;

    // The count holds at the terminal value instead of wrapping; the sequencer
    // leaves SETTLE on that same cycle, so holding only matters if up_i is
    // left asserted by mistake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (up_i && !done_o) begin
            count_r <= count_r + one_lp;
        end
    end

    assign done_o = (count_r == terminal_lp);

endmodule

// File: rtl/bsg_level_shift_sink_sequencer.sv
// ----------------------------------------------------------------------------
// bsg_level_shift_sink_sequencer
//
// Receive-domain end of a gated level-shift crossing. Opens the crossing by
// raising en_o (which releases the source-side clamp), waits settle_cycles_p
// cycles for the shifted levels to become trustworthy, then samples
// v1_data_i into data_o and presents it with a valid/yumi handshake. When
// the open request drops, any pending sample is drained before en_o falls.
//
// Parameters:
//   width_p          data width crossing the shifter
//   settle_cycles_p  cycles en_o must be high before data is trusted (>=1)
//
// Ports:
//   clk_i      in   sink-domain clock
//   reset_i    in   asynchronous, active-high reset
//   en_req_i   in   level request: 1 = open the crossing, 0 = close it
//   v1_data_i  in   data from the level-shift cells (0 while clamped)
//   en_o       out  registered enable to the source-side clamp
//   on_o       out  registered status, high while in ON
//   v_o        out  data_o holds an unconsumed sample
//   data_o     out  registered sample
//   yumi_i     in   consumer takes data_o this cycle (only when v_o=1)
//
// Build option:
//   BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN  when defined, a load in ON also
//   requires two identical consecutive samples of v1_data_i.
// ----------------------------------------------------------------------------
module bsg_level_shift_sink_sequencer
    import bsg_level_shift_pkg::*;
#(
    parameter int width_p         = bsg_level_shift_width_gp,
    parameter int settle_cycles_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_req_i,
    input  logic [width_p-1:0] v1_data_i,
    output logic               en_o,
    output logic               on_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    bsg_level_shift_sink_state_e state_r;

    logic settle_done;
    logic sample_match;
    logic load;

    // The counter is only live in SETTLE; everywhere else it is held at zero
    // so every entry into SETTLE starts a full settle period.
    bsg_level_shift_settle_counter #(
        .settle_cycles_p(settle_cycles_p)
    ) settle_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(state_r != SETTLE),
        .up_i   (state_r == SETTLE),
        .done_o (settle_done)
    );

`ifdef BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN
    logic [width_p-1:0] history_r;
    logic               history_v_r;

    // The history register follows v1_data_i every cycle in ON. Outside ON it
    // is cleared, and history_v_r marks that it holds a real sample, so the
    // first ON cycle can never load: a load needs two matching samples both
    // taken while the crossing is fully settled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            history_r   <= '0;
            history_v_r <= 1'b0;
        end else if (state_r == ON) begin
            history_r   <= v1_data_i;
            history_v_r <= 1'b1;
        end else begin
            history_r   <= '0;
            history_v_r <= 1'b0;
        end
    end

    assign sample_match = history_v_r && (v1_data_i == history_r);
`else
    assign sample_match = 1'b1;
`endif

    // A new sample may be taken while the crossing is open and requested,
    // and the output slot is either empty or being consumed this cycle.
    assign load = (state_r == ON) && en_req_i && (!v_o || yumi_i) && sample_match;

    // Sequencer state and all outputs live in one register block so en_o,
    // on_o, v_o and data_o are glitch-free flops. en_o is high in every state
    // except OFF; on_o is high only in ON. A close request in SETTLE goes
    // straight to OFF since nothing can be pending there, whereas in ON it
    // detours through DRAIN until the consumer has taken any held sample.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= OFF;
            en_o    <= 1'b0;
            on_o    <= 1'b0;
            v_o     <= 1'b0;
            data_o  <= '0;
        end else begin
            case (state_r)
                OFF: begin
                    if (en_req_i) begin
                        state_r <= SETTLE;
                        en_o    <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (!en_req_i) begin
                        state_r <= OFF;
                        en_o    <= 1'b0;
                    end else if (settle_done) begin
                        state_r <= ON;
                        on_o    <= 1'b1;
                    end
                end

                ON: begin
                    if (!en_req_i) begin
                        state_r <= DRAIN;
                        on_o    <= 1'b0;
                        if (yumi_i) begin
                            v_o <= 1'b0;
                        end
                    end else if (load) begin
                        data_o <= v1_data_i;
                        v_o    <= 1'b1;
                    end else if (yumi_i) begin
                        v_o <= 1'b0;
                    end
                end

                DRAIN: begin
                    if (!v_o || yumi_i) begin
                        state_r <= OFF;
                        en_o    <= 1'b0;
                        v_o     <= 1'b0;
                    end
                end

                default: begin
                    state_r <= OFF;
                    en_o    <= 1'b0;
                    on_o    <= 1'b0;
                    v_o     <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The consumer must never take data that is not there.
    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_level_shift_sink_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bsg_level_shift_sink_sequencer
//
// Self-checking bench for bsg_level_shift_sink_sequencer (width_p=16,
// settle_cycles_p=4). Directed scenarios cover the opening latency,
// streaming, close/drain, settle abort and asynchronous reset; a randomized
// phase then runs against a behavioural model kept in this file.
// Honours BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN when defined.
// ----------------------------------------------------------------------------
module tb_bsg_level_shift_sink_sequencer;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         en_req_i;
    logic [W-1:0] v1_data_i;
    logic         en_o;
    logic         on_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: the crossing is either closed, open and settling
    // with some cycles left, open and on, or open and draining.
    bit           m_en;
    bit           m_on;
    bit           m_drain;
    int           m_settle_left;
    bit           m_have;
    logic [W-1:0] m_data;
    logic [W-1:0] m_prev;
    bit           m_prev_ok;

    bsg_level_shift_sink_sequencer #(
        .width_p(W),
        .settle_cycles_p(S)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_req_i (en_req_i),
        .v1_data_i(v1_data_i),
        .en_o     (en_o),
        .on_o     (on_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i)
    );

    // Free-running sink clock, period 10.
    always #5 clk_i = ~clk_i;

    // Safety net so the run always ends even if something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel(input string ctx);
        checkOutput({ctx, " en_o"}, 32'(en_o), 32'(m_en));
        checkOutput({ctx, " on_o"}, 32'(on_o), 32'(m_on));
        checkOutput({ctx, " v_o"}, 32'(v_o), 32'(m_have));
        checkOutput({ctx, " data_o"}, 32'(data_o), 32'(m_data));
    endtask

    task automatic modelReset();
        m_en          = 1'b0;
        m_on          = 1'b0;
        m_drain       = 1'b0;
        m_settle_left = 0;
        m_have        = 1'b0;
        m_data        = '0;
        m_prev        = '0;
        m_prev_ok     = 1'b0;
    endtask

    // One clock edge of the model, using the inputs as they stood at the edge.
    task automatic modelStep();
        bit match;
        if (!m_en) begin
            if (en_req_i) begin
                m_en          = 1'b1;
                m_settle_left = S;
            end
        end else if (m_settle_left > 0) begin
            if (!en_req_i) begin
                m_en          = 1'b0;
                m_settle_left = 0;
            end else begin
                m_settle_left--;
                if (m_settle_left == 0) begin
                    m_on      = 1'b1;
                    m_prev_ok = 1'b0;
                end
            end
        end else if (!m_drain) begin
            match = 1'b1;
`ifdef BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN
            match     = m_prev_ok && (v1_data_i == m_prev);
            m_prev    = v1_data_i;
            m_prev_ok = 1'b1;
`endif
            if (!en_req_i) begin
                m_on    = 1'b0;
                m_drain = 1'b1;
                if (yumi_i) m_have = 1'b0;
            end else if ((!m_have || yumi_i) && match) begin
                m_have = 1'b1;
                m_data = v1_data_i;
            end else if (yumi_i) begin
                m_have = 1'b0;
            end
        end else begin
            if (!m_have || yumi_i) begin
                m_have  = 1'b0;
                m_en    = 1'b0;
                m_drain = 1'b0;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass,
    // advance the model, then check at the next falling edge.
    task automatic applyStimulus(input logic en, input logic [W-1:0] d, input logic y, input string ctx);
        en_req_i  = en;
        v1_data_i = d;
        yumi_i    = y;
        @(posedge clk_i);
        modelStep();
        @(negedge clk_i);
        checkModel(ctx);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic asyncReset(input string ctx);
        #2;
        reset_i = 1'b1;
        #1;
        modelReset();
        checkOutput({ctx, " rst en_o"}, 32'(en_o), 32'd0);
        checkOutput({ctx, " rst on_o"}, 32'(on_o), 32'd0);
        checkOutput({ctx, " rst v_o"}, 32'(v_o), 32'd0);
        checkOutput({ctx, " rst data_o"}, 32'(data_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        logic         r_en;
        logic [W-1:0] r_d;
        logic         r_y;

        reset_i   = 1'b1;
        en_req_i  = 1'b0;
        v1_data_i = '0;
        yumi_i    = 1'b0;
        modelReset();
        repeat (2) @(negedge clk_i);
        checkOutput("reset en_o", 32'(en_o), 32'd0);
        checkOutput("reset on_o", 32'(on_o), 32'd0);
        checkOutput("reset v_o", 32'(v_o), 32'd0);
        checkOutput("reset data_o", 32'(data_o), 32'd0);
        reset_i = 1'b0;

        // Opening latency: en_o one cycle after the request, on_o after the
        // settle period, first sample one cycle later.
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 16'hA5A5, 1'b0, $sformatf("open c%0d", k));
            checkOutput($sformatf("open c%0d en_o", k), 32'(en_o), 32'd1);
            checkOutput($sformatf("open c%0d on_o", k), 32'(on_o), (k >= S + 1) ? 32'd1 : 32'd0);
`ifndef BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN
            checkOutput($sformatf("open c%0d v_o", k), 32'(v_o), (k >= S + 2) ? 32'd1 : 32'd0);
`endif
        end
`ifndef BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN
        checkOutput("first sample", 32'(data_o), 32'h0000A5A5);
`endif

        // Held sample must not move while the consumer waits.
        applyStimulus(1'b1, 16'h1111, 1'b0, "hold1");
        applyStimulus(1'b1, 16'h2222, 1'b0, "hold2");

        // Streaming with yumi every cycle: data follows one cycle late.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, W'(i), m_have, $sformatf("stream %0d", i));
`ifndef BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN
            checkOutput($sformatf("stream %0d data", i), 32'(data_o), 32'(i));
            checkOutput($sformatf("stream %0d v_o", i), 32'(v_o), 32'd1);
`endif
        end

        // Close with 00FF pending: drain, with a re-raised request ignored.
        applyStimulus(1'b1, 16'h00FF, m_have, "load ff");
        applyStimulus(1'b1, 16'h00FF, m_have, "load ff2");
        applyStimulus(1'b0, 16'h0000, 1'b0, "drain1");
        checkOutput("drain1 en_o", 32'(en_o), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, "drain2");
        applyStimulus(1'b1, 16'h0000, 1'b0, "drain3");
        checkOutput("drain3 en_o", 32'(en_o), 32'd1);
        applyStimulus(1'b1, 16'h0000, m_have, "drain yumi");
        checkOutput("drain yumi en_o", 32'(en_o), 32'd0);
`ifndef BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN
        checkOutput("drain yumi data_o", 32'(data_o), 32'h000000FF);
`endif

        // Request still high in OFF: a full settle period repeats.
        for (int k = 1; k <= S + 1; k++) begin
            applyStimulus(1'b1, 16'h0042, 1'b0, $sformatf("reopen c%0d", k));
            checkOutput($sformatf("reopen c%0d on_o", k), 32'(on_o), (k == S + 1) ? 32'd1 : 32'd0);
        end

        // Back to OFF, then abort in the second cycle of SETTLE.
        applyStimulus(1'b0, 16'h0000, m_have, "close a");
        applyStimulus(1'b0, 16'h0000, m_have, "close b");
        applyStimulus(1'b1, 16'h0007, 1'b0, "abort s1");
        applyStimulus(1'b1, 16'h0007, 1'b0, "abort s2");
        applyStimulus(1'b0, 16'h0007, 1'b0, "abort drop");
        checkOutput("abort en_o", 32'(en_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 16'h0007, 1'b0, $sformatf("abort idle %0d", k));
            checkOutput($sformatf("abort idle %0d v_o", k), 32'(v_o), 32'd0);
        end

        // Reach ON with a pending sample, then reset asynchronously.
        for (int k = 0; k < S + 3; k++) begin
            applyStimulus(1'b1, 16'h1234, 1'b0, $sformatf("pre-reset %0d", k));
        end
        asyncReset("mid-on");

`ifdef BSG_LEVEL_SHIFT_SINK_GLITCH_FILTER_EN
        // Alternating data never loads; a repeated value does.
        for (int k = 0; k < S + 1; k++) applyStimulus(1'b1, 16'h0000, 1'b0, "gf open");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, (k % 2 == 0) ? 16'h0001 : 16'h0002, 1'b0, "gf alt");
            checkOutput("gf alt v_o", 32'(v_o), 32'd0);
        end
        applyStimulus(1'b1, 16'h0003, 1'b0, "gf 3a");
        applyStimulus(1'b1, 16'h0003, 1'b0, "gf 3b");
        checkOutput("gf 3 v_o", 32'(v_o), 32'd1);
        checkOutput("gf 3 data", 32'(data_o), 32'd3);
        asyncReset("gf end");
`endif

        // Randomized phase against the model.
        r_en = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 11) == 0) r_en = ~r_en;
            r_d = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            r_y = m_have && ($urandom_range(0, 2) != 0);
            applyStimulus(r_en, r_d, r_y, $sformatf("rand %0d", n));
            if ($urandom_range(0, 299) == 0) asyncReset($sformatf("rand %0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
